// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver (scan code set 2) that turns make/break byte
// sequences into the 4-bit key code used by the player movement controller.
module ps2_key_decoder #(
  parameter int         TIMEOUT   = 100000,
  parameter logic [3:0] KEY_NONE  = 4'h0,
  parameter logic [3:0] KEY_A     = 4'h1,
  parameter logic [3:0] KEY_D     = 4'h2,
  parameter logic [3:0] KEY_W     = 4'h3,
  parameter logic [3:0] KEY_S     = 4'h4,
  parameter logic [3:0] KEY_SPACE = 4'h5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key,
  output logic       code_valid,
  output logic [7:0] scan_code,
  output logic       frame_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam int         TW       = $clog2(TIMEOUT + 1);

  // Synchronizer flops idle high so a reset never fabricates a falling edge.
  logic ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
  logic ps2_data_meta_q, ps2_data_sync_q;

  logic [1:0]    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          break_q, break_d;
  logic          ext_q, ext_d;
  logic [3:0]    key_q, key_d;
  logic [7:0]    scan_q, scan_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic       fe;
  logic       frame_ok;
  logic [7:0] rx_byte;
  logic [3:0] mapped;

  // Translate a set-2 make code into the movement key code.
  function automatic logic [3:0] map_scan(input logic [7:0] b);
    case (b)
      8'h1C:   map_scan = KEY_A;
      8'h23:   map_scan = KEY_D;
      8'h1D:   map_scan = KEY_W;
      8'h1B:   map_scan = KEY_S;
      8'h29:   map_scan = KEY_SPACE;
      default: map_scan = KEY_NONE;
    endcase
  endfunction

  assign fe       = ps2_clk_prev_q & ~ps2_clk_sync_q;
  assign rx_byte  = shift_q[7:0];
  // Odd parity over data+parity, and stop bit must be high.
  assign frame_ok = shift_q[9] & (^shift_q[8:0]);
  // Extended keys are deliberately ignored by treating them as unmapped.
  assign mapped   = ext_q ? KEY_NONE : map_scan(rx_byte);

  // Two-flop synchronizers plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      ps2_clk_meta_q  <= 1'b1;
      ps2_clk_sync_q  <= 1'b1;
      ps2_clk_prev_q  <= 1'b1;
      ps2_data_meta_q <= 1'b1;
      ps2_data_sync_q <= 1'b1;
    end else begin
      ps2_clk_meta_q  <= ps2_clk;
      ps2_clk_sync_q  <= ps2_clk_meta_q;
      ps2_clk_prev_q  <= ps2_clk_sync_q;
      ps2_data_meta_q <= ps2_data;
      ps2_data_sync_q <= ps2_data_meta_q;
    end
  end

  // Frame reception, validation and make/break interpretation.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = '0;
    break_d   = break_q;
    ext_d     = ext_q;
    key_d     = key_q;
    scan_d    = scan_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fe) begin
          if (!ps2_data_sync_q) begin
            state_d   = ST_RECV;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RECV: begin
        if (fe) begin
          shift_d = {ps2_data_sync_q, shift_q[9:1]};
          if (bit_cnt_q == 4'd9) begin
            state_d = ST_CHECK;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (to_cnt_q == TW'(TIMEOUT)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          break_d = 1'b0;
          ext_d   = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (frame_ok) begin
          valid_d = 1'b1;
          scan_d  = rx_byte;
          if (rx_byte == 8'hE0) begin
            ext_d = 1'b1;
          end else if (rx_byte == 8'hF0) begin
            break_d = 1'b1;
          end else begin
            if (!break_q) begin
              if (mapped != KEY_NONE) key_d = mapped;
            end else if (mapped == key_q) begin
              key_d = KEY_NONE;
            end
            break_d = 1'b0;
            ext_d   = 1'b0;
          end
        end else begin
          err_d   = 1'b1;
          break_d = 1'b0;
          ext_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any partial frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      to_cnt_q  <= '0;
      break_q   <= 1'b0;
      ext_q     <= 1'b0;
      key_q     <= KEY_NONE;
      scan_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      to_cnt_q  <= to_cnt_d;
      break_q   <= break_d;
      ext_q     <= ext_d;
      key_q     <= key_d;
      scan_q    <= scan_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign key        = key_q;
  assign scan_code  = scan_q;
  assign code_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Receives PS/2 keyboard frames (scan code set 2) on the raw ps2_clk/ps2_data pins.
- Decodes make/break sequences into the 4-bit key code that feeds the player movement controller's key input.
- Sits directly upstream of the player movement FSM, in the clk domain.
- Output key holds the code of the most recently pressed, still-held key; it returns to KEY_NONE when that key is released.

Parameters:
- TIMEOUT, 100000: clk cycles with no ps2_clk falling edge before a partial frame is discarded.
- KEY_NONE, 4'h0: output code when no tracked key is held.
- KEY_A, 4'h1: code for scan 0x1C.
- KEY_D, 4'h2: code for scan 0x23.
- KEY_W, 4'h3: code for scan 0x1D.
- KEY_S, 4'h4: code for scan 0x1B.
- KEY_SPACE, 4'h5: code for scan 0x29.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- key  out  4  currently held key code.
- code_valid  out  1  one-cycle pulse when a complete, parity-correct byte is accepted.
- scan_code  out  8  last accepted byte; holds between frames.
- frame_err  out  1  one-cycle pulse on parity/start/stop error or timeout.

Behaviour:
- Reset values: key=KEY_NONE, scan_code=8'h00, code_valid=0, frame_err=0, FSM=IDLE, break_flag=0, ext_flag=0, bit counter=0, timeout counter=0.
- Input path:
  - ps2_clk and ps2_data each pass through a 2-flop synchronizer.
  - A falling edge (fe) is detected in cycle N when the synced clk was 1 in N-1 and is 0 in N.
  - The data bit is the synced ps2_data value in cycle N.
- FSM states: IDLE, RECV, CHECK.
  - IDLE: on fe with data=0 (start bit) go to RECV and clear the bit counter. On fe with data=1, stay in IDLE and pulse frame_err.
  - RECV: on each fe, shift the bit in, LSB first. Bits 0-7 are data, bit 8 is odd parity, bit 9 is stop. On fe of the stop bit go to CHECK.
  - CHECK (one cycle): the frame is valid if the stop bit is 1 and the XOR of the 8 data bits and parity equals 1.
    - Valid: scan_code updates and code_valid=1 in the cycle after CHECK, then return to IDLE.
    - Invalid: frame_err=1 in that same cycle, scan_code and key unchanged, break_flag and ext_flag cleared, then IDLE.
- Latency: key, scan_code and code_valid update exactly 2 clk cycles after the cycle fe of the stop bit is detected.
- Timeout:
  - In RECV, the counter increments every cycle without fe and clears on fe.
  - When the counter reaches TIMEOUT: go to IDLE, pulse frame_err, clear break_flag and ext_flag. key is unchanged.
- Byte interpretation (valid bytes only):
  - 0xE0: set ext_flag, key unchanged.
  - 0xF0: set break_flag, key unchanged.
  - Otherwise, map the byte to a code; unmapped bytes map to "none".
  - If ext_flag=1, the byte is treated as unmapped (arrows and other extended keys are ignored).
  - Make (break_flag=0) with a mapped code: key = code.
  - Break (break_flag=1): if the mapped code equals the current key, key = KEY_NONE; otherwise key is unchanged.
  - After any non-prefix byte, clear break_flag and ext_flag.
  - Typematic repeat makes of the held key leave key unchanged.
- Simultaneous events: rst has priority over everything. A fe arriving in CHECK is ignored, because a legal PS/2 frame never has one there.
- Reset mid-frame: the partial frame is dropped and the next start bit is received normally.

Test Plan:
- Press/release D: frame 0x23 -> key=4'h2 two cycles after stop-bit fe, code_valid pulse, scan_code=8'h23. Then F0,23 -> key=4'h0 after the 0x23 frame; F0 alone leaves key at 4'h2.
- Overlap: make 0x1C then make 0x23 -> key=4'h2. Break 0x1C (F0,1C) -> key stays 4'h2. Break 0x23 -> key=4'h0.
- Parity error: frame 0x1C with even parity -> frame_err pulse, no code_valid, key and scan_code unchanged. Next good 0x1C frame -> key=4'h1.
- Extended: E0,1C -> key unchanged (KEY_NONE). E0,F0,1C -> key unchanged, flags cleared. Following plain 0x1D -> key=4'h3.
- Timeout: start bit plus 4 data bits, then ps2_clk held high for TIMEOUT cycles -> frame_err pulse, FSM back in IDLE. Full 0x29 frame afterwards -> key=4'h5.
- Reset mid-frame: assert rst after 5 bits of a 0x23 frame -> all outputs return to reset values. Next complete 0x1B frame -> key=4'h4.
